command_word_sequencer: RTL

COMMAND_WORD_SEQUENCER -- requirements
Module: command_word_sequencer

---
 rtl/command_word_sequencer_pkg.sv | 35 +++
 rtl/command_word_sequencer_decoder.sv | 32 +++
 rtl/command_word_sequencer.sv | 140 ++++++++++++++
 3 files changed

// File: rtl/command_word_sequencer_pkg.sv
// -----------------------------------------------------------------------------
// command_word_sequencer_pkg
// Shared 8259A definitions. It holds the sequencer state encoding (3 bits,
// IDLE=0 .. READY=4), the CPU write classes produced by the decoder, and the
// strobe bundle the sequencer registers.
// -----------------------------------------------------------------------------
package command_word_sequencer_pkg;

   typedef enum logic [2:0] {
      SEQ_IDLE      = 3'd0,
      SEQ_WAIT_ICW2 = 3'd1,
      SEQ_WAIT_ICW3 = 3'd2,
      SEQ_WAIT_ICW4 = 3'd3,
      SEQ_READY     = 3'd4
   } seq_state_e;

   // The decoded class of a CPU write, taken from {A0, D4, D3}.
   typedef enum logic [1:0] {
      WR_ICW1    = 2'd0,
      WR_A0_HIGH = 2'd1,
      WR_OCW2    = 2'd2,
      WR_OCW3    = 2'd3
   } write_class_e;

   typedef struct packed {
      logic icw1;
      logic icw2;
      logic icw3;
      logic icw4;
      logic ocw1;
      logic ocw2;
      logic ocw3;
   } strobe_t;

endpackage

// File: rtl/command_word_sequencer_decoder.sv
// -----------------------------------------------------------------------------
// command_word_decoder
// Purely combinational classifier for a CPU write to the 8259A.
//   address_0   in  A0 of the written word
//   bit4        in  D4 of the written word
//   bit3        in  D3 of the written word
//   write_class out ICW1 / A0-high / OCW2 / OCW3
// Every input combination maps to exactly one class.
// -----------------------------------------------------------------------------
module command_word_decoder
   import command_word_sequencer_pkg::*;
(
   input  logic         address_0,
   input  logic         bit4,
   input  logic         bit3,
   output write_class_e write_class
);

   always_comb begin
      write_class = WR_OCW2;
      if (address_0) begin
         write_class = WR_A0_HIGH;
      end else if (bit4) begin
         write_class = WR_ICW1;
      end else if (bit3) begin
         write_class = WR_OCW3;
      end else begin
         write_class = WR_OCW2;
      end
   end

endmodule

// File: rtl/command_word_sequencer.sv
// -----------------------------------------------------------------------------
// command_word_sequencer
// Tracks the 8259A initialisation sequence (ICW1..ICW4) and then routes the
// operation control words (OCW1..OCW3) once initialised.
//   CASCADE_SUPPORT                    param 0 skips ICW3 regardless of SNGL
//   clock                              in    rising-edge system clock
//   reset_n                            in    asynchronous active-low reset
//   write_enable                       in    one-cycle pulse per CPU write
//   address_0                          in    A0 of the written word
//   internal_data_bus[7:0]             in    data of the written word
//   write_initial_command_word_1..4    out   registered one-cycle ICW strobes
//   write_operation_control_word_1..3  out   registered one-cycle OCW strobes
//   initialization_complete            out   high only in READY
//   sequencer_state[2:0]               out   current state encoding
// -----------------------------------------------------------------------------
module command_word_sequencer
   import command_word_sequencer_pkg::*;
#(
   parameter int unsigned CASCADE_SUPPORT = 1
) (
   input  logic       clock,
   input  logic       reset_n,
   input  logic       write_enable,
   input  logic       address_0,
   input  logic [7:0] internal_data_bus,
   output logic       write_initial_command_word_1,
   output logic       write_initial_command_word_2,
   output logic       write_initial_command_word_3,
   output logic       write_initial_command_word_4,
   output logic       write_operation_control_word_1,
   output logic       write_operation_control_word_2,
   output logic       write_operation_control_word_3,
   output logic       initialization_complete,
   output logic [2:0] sequencer_state
);

   seq_state_e   state_q, state_d;
   logic         sngl_q, sngl_d;
   logic         ic4_q, ic4_d;
   strobe_t      strobe_q, strobe_d;
   write_class_e write_class;

   // Only D4, D3, D1 and D0 matter to the sequencer.
   logic data_unused;
   assign data_unused = ^{internal_data_bus[7:5], internal_data_bus[2]};

   command_word_decoder u_decoder (
      .address_0   (address_0),
      .bit4        (internal_data_bus[4]),
      .bit3        (internal_data_bus[3]),
      .write_class (write_class)
   );

   always_comb begin
      state_d  = state_q;
      sngl_d   = sngl_q;
      ic4_d    = ic4_q;
      strobe_d = '0;

      if (write_enable) begin
         unique case (write_class)
            WR_ICW1: begin
               // ICW1 restarts the sequence from any state.
               strobe_d.icw1 = 1'b1;
               sngl_d        = internal_data_bus[1];
               ic4_d         = internal_data_bus[0];
               state_d       = SEQ_WAIT_ICW2;
            end
            WR_A0_HIGH: begin
               unique case (state_q)
                  SEQ_WAIT_ICW2: begin
                     strobe_d.icw2 = 1'b1;
                     if (!sngl_q && (CASCADE_SUPPORT != 0)) begin
                        state_d = SEQ_WAIT_ICW3;
                     end else if (ic4_q) begin
                        state_d = SEQ_WAIT_ICW4;
                     end else begin
                        state_d = SEQ_READY;
                     end
                  end
                  SEQ_WAIT_ICW3: begin
                     strobe_d.icw3 = 1'b1;
                     state_d       = ic4_q ? SEQ_WAIT_ICW4 : SEQ_READY;
                  end
                  SEQ_WAIT_ICW4: begin
                     strobe_d.icw4 = 1'b1;
                     state_d       = SEQ_READY;
                  end
                  SEQ_READY: begin
                     strobe_d.ocw1 = 1'b1;
                  end
                  default: begin
                     // IDLE: nothing to write until an ICW1 arrives.
                  end
               endcase
            end
            WR_OCW2: begin
               if (state_q == SEQ_READY) begin
                  strobe_d.ocw2 = 1'b1;
               end
            end
            WR_OCW3: begin
               if (state_q == SEQ_READY) begin
                  strobe_d.ocw3 = 1'b1;
               end
            end
            default: begin
            end
         endcase
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q  <= SEQ_IDLE;
         sngl_q   <= 1'b1;
         ic4_q    <= 1'b0;
         strobe_q <= '0;
      end else begin
         state_q  <= state_d;
         sngl_q   <= sngl_d;
         ic4_q    <= ic4_d;
         strobe_q <= strobe_d;
      end
   end

   assign write_initial_command_word_1   = strobe_q.icw1;
   assign write_initial_command_word_2   = strobe_q.icw2;
   assign write_initial_command_word_3   = strobe_q.icw3;
   assign write_initial_command_word_4   = strobe_q.icw4;
   assign write_operation_control_word_1 = strobe_q.ocw1;
   assign write_operation_control_word_2 = strobe_q.ocw2;
   assign write_operation_control_word_3 = strobe_q.ocw3;

   // State and the final ICW strobe load on the same edge, so this rises
   // together with that strobe.
   assign initialization_complete = (state_q == SEQ_READY);
   assign sequencer_state         = state_q;

endmodule
